// File: rtl/framebuffer_db.sv
// framebuffer_db
// ----------------------------------------------------------------------------
// Double-buffered framebuffer. The draw engine writes the back bank (!front)
// and the VGA side reads the front bank. A requested swap is deferred to the
// next frame_start, so the bank on screen never changes partway through a
// frame. If FRAMEBUFFER_CLEAR_EN is defined, a clear engine can fill the back
// bank with one colour, one pixel per clock.
//
// Parameters : CORDW (coordinate width), WIDTH, HEIGHT (visible area),
//              CHANW (bits per channel; pixel = {r,g,b}, 3*CHANW bits)
// Ports      : clk, rst (synchronous, active-low)
//              draw    : we, x, y, color, oob (dropped out-of-range write)
//              display : rd_en, sx, sy -> r, g, b, rd_valid (1-cycle latency)
//              swap    : swap_req, frame_start -> swap_pending, front
//              clear   : clear_req, clear_color -> busy
// Macro      : FRAMEBUFFER_CLEAR_EN enables the clear engine. Without it,
//              clear_req and clear_color are ignored and busy is tied to 0.
// ----------------------------------------------------------------------------
module framebuffer_db #(
  parameter int CORDW  = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CHANW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [CORDW-1:0]   x,
  input  logic [CORDW-1:0]   y,
  input  logic [3*CHANW-1:0] color,
  input  logic               rd_en,
  input  logic [CORDW-1:0]   sx,
  input  logic [CORDW-1:0]   sy,
  output logic [CHANW-1:0]   r,
  output logic [CHANW-1:0]   g,
  output logic [CHANW-1:0]   b,
  output logic               rd_valid,
  input  logic               swap_req,
  input  logic               frame_start,
  output logic               swap_pending,
  output logic               front,
  input  logic               clear_req,
  input  logic [3*CHANW-1:0] clear_color,
  output logic               busy,
  output logic               oob
);

  localparam int PIXW  = 3 * CHANW;
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int ADDRW = $clog2(NPIX);
  // Wide enough to hold y*WIDTH + x for any coordinate, so nothing truncates
  // before the result is narrowed.
  localparam int MULW  = CORDW + $clog2(WIDTH + 1) + 1;

  // Each bank occupies a power-of-two region, so the word index is just
  // {bank, address} and no bank-offset adder is needed.
  logic [PIXW-1:0] mem [0:(2**(ADDRW+1))-1];

  function automatic logic [ADDRW-1:0] lin_addr(input logic [CORDW-1:0] cx,
                                                input logic [CORDW-1:0] cy);
    return ADDRW'(MULW'(cy) * MULW'(WIDTH) + MULW'(cx));
  endfunction

  logic            draw_in_range, rd_in_range, draw_acc;
  logic            wr_en;
  logic [ADDRW:0]  wr_idx, rd_idx;
  logic [PIXW-1:0] wr_data;
  logic [PIXW-1:0] rd_data_q;

  logic front_q, front_d;
  logic swap_pending_q, swap_pending_d;
  logic oob_q, oob_d;
  logic rd_valid_q, rd_valid_d;
  // Forces r/g/b to zero: set by reset and by an out-of-range read.
  logic rd_zero_q, rd_zero_d;

  assign draw_in_range = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  assign rd_in_range   = (int'(sx) < WIDTH) && (int'(sy) < HEIGHT);
  assign draw_acc      = we && !busy && draw_in_range;
  assign rd_idx        = {front_q, rd_in_range ? lin_addr(sx, sy) : '0};

`ifdef FRAMEBUFFER_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDRW-1:0]  clr_addr_q, clr_addr_d;
  logic [PIXW-1:0]   clr_color_q, clr_color_d;
  logic              clr_bank_q, clr_bank_d;

  assign busy = (state_q == S_CLEAR);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_bank_d  = clr_bank_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d     = S_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
          // Latch the target bank; swaps are held off while busy, so it
          // stays the back bank for the whole clear anyway.
          clr_bank_d  = ~front_q;
        end
      end
      S_CLEAR: begin
        if (clr_addr_q == ADDRW'(NPIX - 1)) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      clr_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      clr_bank_q  <= clr_bank_d;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_color};
  assign busy         = 1'b0;
`endif

  // Single write port shared by the draw engine and the clear engine; they
  // never collide because draw writes are refused while busy.
  always_comb begin
    wr_en   = draw_acc;
    wr_idx  = {~front_q, lin_addr(x, y)};
    wr_data = color;
`ifdef FRAMEBUFFER_CLEAR_EN
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = {clr_bank_q, clr_addr_q};
      wr_data = clr_color_q;
    end
`endif
  end

  // Memory array: contents are not reset; read data is registered.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_idx];
    end
  end

  always_comb begin
    front_d        = front_q;
    swap_pending_d = swap_pending_q;
    // Uses the registered pending flag, so a swap_req arriving together with
    // frame_start waits for the following frame boundary.
    if (frame_start && swap_pending_q && !busy) begin
      front_d        = ~front_q;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
    oob_d      = we && !busy && !draw_in_range;
    rd_valid_d = rd_en;
    rd_zero_d  = rd_en ? !rd_in_range : rd_zero_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      oob_q          <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_zero_q      <= 1'b1;
    end else begin
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      oob_q          <= oob_d;
      rd_valid_q     <= rd_valid_d;
      rd_zero_q      <= rd_zero_d;
    end
  end

  assign front        = front_q;
  assign swap_pending = swap_pending_q;
  assign oob          = oob_q;
  assign rd_valid     = rd_valid_q;
  assign r = rd_zero_q ? '0 : rd_data_q[3*CHANW-1:2*CHANW];
  assign g = rd_zero_q ? '0 : rd_data_q[2*CHANW-1:CHANW];
  assign b = rd_zero_q ? '0 : rd_data_q[CHANW-1:0];

endmodule

// File: tb/tb_framebuffer_db.sv
// Testbench for framebuffer_db on a 10x10 screen. A shadow model of both banks
// plus a queue of expected read words forms the scoreboard: every read pushes
// its expected pixel, and a monitor pops and compares on the following cycle.
// The clear-engine checks are built only when FRAMEBUFFER_CLEAR_EN is defined.
module tb_framebuffer_db;
  localparam int CORDW  = 10;
  localparam int WIDTH  = 10;
  localparam int HEIGHT = 10;
  localparam int CHANW  = 4;
  localparam int PIXW   = 3 * CHANW;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             we = 1'b0, rd_en = 1'b0, swap_req = 1'b0;
  logic             frame_start = 1'b0, clear_req = 1'b0;
  logic [CORDW-1:0] x = '0, y = '0, sx = '0, sy = '0;
  logic [PIXW-1:0]  color = '0, clear_color = '0;
  logic [CHANW-1:0] r, g, b;
  logic             rd_valid, swap_pending, front, busy, oob;

  always #5 clk = ~clk;

  framebuffer_db #(
    .CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CHANW(CHANW)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .x(x), .y(y), .color(color),
    .rd_en(rd_en), .sx(sx), .sy(sy), .r(r), .g(g), .b(b),
    .rd_valid(rd_valid), .swap_req(swap_req), .frame_start(frame_start),
    .swap_pending(swap_pending), .front(front), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .oob(oob)
  );

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [PIXW-1:0] model [2][NPIX];
  logic            m_front = 1'b0;
  logic [PIXW-1:0] exp_q [$];

  typedef struct {
    int              xi;
    int              yi;
    logic [PIXW-1:0] c;
    logic            exp_oob;
  } wvec_t;
  wvec_t wtab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Draw write into the back bank; the model only takes in-range writes.
  task automatic wr(input int xi, input int yi, input logic [PIXW-1:0] c);
    we = 1'b1; x = xi[CORDW-1:0]; y = yi[CORDW-1:0]; color = c;
    step();
    we = 1'b0;
    if (xi < WIDTH && yi < HEIGHT) model[!m_front][yi*WIDTH + xi] = c;
  endtask

  // Display read of the front bank; expected word goes on the scoreboard.
  task automatic rd(input int xi, input int yi);
    rd_en = 1'b1; sx = xi[CORDW-1:0]; sy = yi[CORDW-1:0];
    if (xi < WIDTH && yi < HEIGHT) exp_q.push_back(model[m_front][yi*WIDTH + xi]);
    else exp_q.push_back('0);
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk({tag, "_pend_set"}, swap_pending, 1);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_front = ~m_front;
    chk({tag, "_front"}, front, m_front);
    chk({tag, "_pend_clr"}, swap_pending, 0);
  endtask

  // Read monitor: rd_valid must follow rd_en by one cycle, and each valid
  // word must match the head of the scoreboard.
  always @(posedge clk) begin
    logic had;
    logic [PIXW-1:0] e;
    had = rd_en & rst;
    #2;
    chk("rd_valid", rd_valid, had);
    if (had) begin
      chk("rd_queue_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_rgb", {r, g, b}, e);
      end
    end
  end

  initial begin
    int cnt;

    wtab[0] = '{10,   0,    12'hFFF, 1'b1};
    wtab[1] = '{0,    10,   12'hABC, 1'b1};
    wtab[2] = '{1023, 1023, 12'h111, 1'b1};
    wtab[3] = '{9,    9,    12'h7E7, 1'b0};
    wtab[4] = '{0,    0,    12'h0C3, 1'b0};
    wtab[5] = '{15,   3,    12'h222, 1'b1};
    wtab[6] = '{5,    5,    12'h555, 1'b0};
    wtab[7] = '{9,    10,   12'h999, 1'b1};

    // Reset state
    step();
    step();
    chk("rst_front", front, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oob", oob, 0);
    chk("rst_rgb", {r, g, b}, 0);
    rst = 1'b1;

    // Give both banks known contents
    for (int a = 0; a < NPIX; a++) wr(a % WIDTH, a / WIDTH, 12'(a * 53 + 12'h101));
    do_swap("fill1");
    for (int a = 0; a < NPIX; a++) wr(a % WIDTH, a / WIDTH, 12'(a * 29) ^ 12'hA5A);
    do_swap("fill0");

    // Basic draw, swap, read back
    wr(3, 4, 12'hF0A);
    do_swap("basic");
    rd(3, 4);
    chk("basic_rgb", {r, g, b}, 12'hF0A);

    // Table of draw writes including out-of-range coordinates
    foreach (wtab[i]) begin
      wr(wtab[i].xi, wtab[i].yi, wtab[i].c);
      chk($sformatf("oob_vec%0d", i), oob, wtab[i].exp_oob);
      step();
      chk($sformatf("oob_pulse%0d", i), oob, 0);
    end
    do_swap("tab");
    rd(10, 0);
    chk("oob_read_rgb", {r, g, b}, 0);
    for (int a = 0; a < NPIX; a++) rd(a % WIDTH, a / WIDTH);

    // swap_req and frame_start together: swap waits for next boundary
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("same_front", front, m_front);
    chk("same_pend", swap_pending, 1);
    step();
    step();
    chk("same_hold", swap_pending, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_front = ~m_front;
    chk("same_front2", front, m_front);
    chk("same_pend2", swap_pending, 0);

`ifdef FRAMEBUFFER_CLEAR_EN
    // Clear the back bank; swap and draw are held off while busy
    clear_req = 1'b1; clear_color = 12'h123;
    step();
    clear_req = 1'b0; clear_color = 12'h000;
    chk("busy_rise", busy, 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      we = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
      if (cnt == 10) swap_req = 1'b1;
      if (cnt == 20) frame_start = 1'b1;
      if (cnt == 30) begin we = 1'b1; x = '0; y = '0; color = 12'hBEE; end
      step();
      if (cnt == 20) begin
        chk("busy_front_hold", front, m_front);
        chk("busy_pend_hold", swap_pending, 1);
      end
      if (cnt == 30) chk("busy_no_oob", oob, 0);
    end
    we = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    chk("busy_len", cnt, NPIX);
    chk("busy_pend_after", swap_pending, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_front = ~m_front;
    chk("clear_swap_front", front, m_front);
    chk("clear_swap_pend", swap_pending, 0);
    for (int a = 0; a < NPIX; a++) model[m_front][a] = 12'h123;
    for (int a = 0; a < NPIX; a++) rd(a % WIDTH, a / WIDTH);
`else
    // Clear engine absent: request is ignored, draws keep working
    clear_req = 1'b1; clear_color = 12'h123;
    step();
    clear_req = 1'b0;
    chk("noclear_busy", busy, 0);
    wr(0, 0, 12'h3C3);
    chk("noclear_oob", oob, 0);
    do_swap("noclear");
    rd(0, 0);
    chk("noclear_rgb", {r, g, b}, 12'h3C3);
`endif

    // Reset in the middle of a clear / pending swap
    do_swap("pre_rst");
`ifdef FRAMEBUFFER_CLEAR_EN
    clear_req = 1'b1; clear_color = 12'h456;
    step();
    clear_req = 1'b0;
`endif
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("mid_pend", swap_pending, 1);
    repeat (48) step();
`ifdef FRAMEBUFFER_CLEAR_EN
    chk("mid_busy", busy, 1);
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_front", front, 0);
    chk("mrst_pend", swap_pending, 0);
    chk("mrst_oob", oob, 0);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_r", r, 0);
    chk("mrst_g", g, 0);
    chk("mrst_b", b, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
